cas_player: RTL

Cassette playback transmitter for the MSX1 core. It takes tape data from a byte stream, fed by the CAS image loader over a valid/ready handshake. It generates the MSX 1200-baud FSK waveform that drives the core's `cas_audio_in` input, which the PPI/PSG path and BIOS tape routines decode. It sits between the SDRAM-backed CAS fetcher and the `msx1` top, and is paced by the 3.58 MHz CPU clock enable.

---
 rtl/cas_pkg.sv | 29 ++
 rtl/cas_tone_gen.sv | 83 ++++++++
 rtl/cas_player.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cas_pkg.sv
// Shared types and defaults for the MSX cassette playback transmitter.
package cas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_HEADER = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd5
    } cas_state_t;

    localparam int CAS_HALF_2400 = 746;
    localparam int CAS_HALF_1200 = 1491;
    localparam int CAS_GAP_TICKS = 3579545;
    localparam int CAS_LONG_HDR  = 32000;
    localparam int CAS_SHORT_HDR = 8000;
    localparam int CAS_STOP_BITS = 2;

    localparam int CAS_HALF_W = 11;
    localparam int CAS_GAP_W  = 22;
    localparam int CAS_HDR_W  = 15;

    // A 0 bit is one full 1200 Hz cycle, a 1 bit two full 2400 Hz cycles.
    function automatic logic [CAS_HDR_W-1:0] cas_bit_halves(input logic b);
        return b ? 15'd4 : 15'd2;
    endfunction

endpackage

// File: rtl/cas_tone_gen.sv
// Square-wave burst of num_half half-periods of half_len ticks; high from the start edge, ends low.
// done pulses combinationally on the tick ending the burst; a start in that clk chains with no gap.
module cas_tone_gen
    import cas_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  clr,
    input  logic                  start,
    input  logic [CAS_HALF_W-1:0] half_len,
    input  logic [CAS_HDR_W-1:0]  num_half,
    output logic                  level,
    output logic                  done
);

    logic [CAS_HALF_W-1:0] cnt_q, cnt_d;
    logic [CAS_HALF_W-1:0] len_q, len_d;
    logic [CAS_HDR_W-1:0]  half_q, half_d;
    logic [CAS_HDR_W-1:0]  num_q, num_d;
    logic                  level_q, level_d;
    logic                  active_q, active_d;
    logic                  half_end;

    assign half_end = active_q & ce & (cnt_q == len_q - 11'd1);
    assign done     = half_end & (half_q == num_q - 15'd1);
    assign level    = level_q;

    always_comb begin
        cnt_d    = cnt_q;
        len_d    = len_q;
        half_d   = half_q;
        num_d    = num_q;
        level_d  = level_q;
        active_d = active_q;
        if (clr) begin
            cnt_d    = '0;
            half_d   = '0;
            level_d  = 1'b0;
            active_d = 1'b0;
        end else if (start) begin
            cnt_d    = '0;
            half_d   = '0;
            len_d    = half_len;
            num_d    = num_half;
            level_d  = 1'b1;
            active_d = 1'b1;
        end else if (active_q && ce) begin
            if (half_end) begin
                cnt_d = '0;
                if (done) begin
                    half_d   = '0;
                    level_d  = 1'b0;
                    active_d = 1'b0;
                end else begin
                    half_d  = half_q + 15'd1;
                    level_d = ~level_q;
                end
            end else begin
                cnt_d = cnt_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            len_q    <= '0;
            half_q   <= '0;
            num_q    <= '0;
            level_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            half_q   <= half_d;
            num_q    <= num_d;
            level_q  <= level_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/cas_player.sv
// MSX 1200-baud FSK cassette transmitter; first output high 1 clk after a transfer; data_ready only in IDLE with play.
// Optional CAS_MOTOR_GATE_EN: motor=0 freezes all timing, forces the output low and holds off data_ready.
module cas_player
    import cas_pkg::*;
#(
    parameter int HALF_2400 = CAS_HALF_2400,
    parameter int HALF_1200 = CAS_HALF_1200,
    parameter int GAP_TICKS = CAS_GAP_TICKS,
    parameter int LONG_HDR  = CAS_LONG_HDR,
    parameter int SHORT_HDR = CAS_SHORT_HDR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_3m58,
    input  logic       play,
    input  logic       motor,
    input  logic       data_valid,
    input  logic [7:0] data,
    input  logic       data_hdr,
    output logic       data_ready,
    output logic       cas_audio,
    output logic       busy
);

    localparam logic [CAS_HALF_W-1:0] LEN_2400  = CAS_HALF_W'(HALF_2400);
    localparam logic [CAS_HALF_W-1:0] LEN_1200  = CAS_HALF_W'(HALF_1200);
    localparam logic [CAS_GAP_W-1:0]  GAP_LAST  = CAS_GAP_W'(GAP_TICKS - 1);
    localparam logic [CAS_HDR_W-1:0]  NUM_LONG  = CAS_HDR_W'(LONG_HDR);
    localparam logic [CAS_HDR_W-1:0]  NUM_SHORT = CAS_HDR_W'(SHORT_HDR);
    localparam logic [1:0]            STOP_LAST = 2'(CAS_STOP_BITS - 1);

    logic run;
`ifdef CAS_MOTOR_GATE_EN
    assign run = motor;
`else
    logic motor_unused;
    assign run          = 1'b1;
    assign motor_unused = motor;
`endif

    cas_state_t            state_q, state_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [1:0]            stop_cnt_q, stop_cnt_d;
    logic [CAS_GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  hdr_long_q, hdr_long_d;
    logic                  armed_q, armed_d;

    logic                  ce_run;
    logic                  xfer;
    logic                  tone_start;
    logic                  tone_clr;
    logic [CAS_HALF_W-1:0] tone_len;
    logic [CAS_HDR_W-1:0]  tone_num;
    logic                  tone_level;
    logic                  tone_done;

    // armed_q keeps data_ready low out of reset until play has been sampled once.
    assign ce_run     = ce_3m58 & run;
    assign data_ready = (state_q == ST_IDLE) & play & armed_q & run;
    assign xfer       = data_valid & data_ready;
    assign cas_audio  = tone_level & run;
    assign busy       = (state_q != ST_IDLE);
    assign armed_d    = play;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        hdr_long_d = hdr_long_q;
        tone_start = 1'b0;
        tone_clr   = 1'b0;
        tone_len   = LEN_2400;
        tone_num   = cas_bit_halves(1'b1);
        if (!play) begin
            state_d    = ST_IDLE;
            tone_clr   = 1'b1;
            shreg_d    = '0;
            bit_idx_d  = '0;
            stop_cnt_d = '0;
            gap_cnt_d  = '0;
            hdr_long_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        if (data_hdr) begin
                            hdr_long_d = data[0];
                            gap_cnt_d  = '0;
                            state_d    = ST_GAP;
                        end else begin
                            shreg_d    = data;
                            tone_start = 1'b1;
                            tone_len   = LEN_1200;
                            tone_num   = cas_bit_halves(1'b0);
                            state_d    = ST_START;
                        end
                    end
                end
                ST_GAP: begin
                    if (ce_run) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_d  = '0;
                            tone_start = 1'b1;
                            tone_num   = hdr_long_q ? NUM_LONG : NUM_SHORT;
                            state_d    = ST_HEADER;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 22'd1;
                        end
                    end
                end
                ST_HEADER: begin
                    if (tone_done) state_d = ST_IDLE;
                end
                ST_START: begin
                    if (tone_done) begin
                        bit_idx_d  = '0;
                        tone_start = 1'b1;
                        tone_len   = shreg_q[0] ? LEN_2400 : LEN_1200;
                        tone_num   = cas_bit_halves(shreg_q[0]);
                        state_d    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // shreg_q[0] is always the bit currently on the wire.
                    if (tone_done) begin
                        tone_start = 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            stop_cnt_d = '0;
                            state_d    = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            shreg_d   = {1'b0, shreg_q[7:1]};
                            tone_len  = shreg_q[1] ? LEN_2400 : LEN_1200;
                            tone_num  = cas_bit_halves(shreg_q[1]);
                        end
                    end
                end
                ST_STOP: begin
                    if (tone_done) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            stop_cnt_d = stop_cnt_q + 2'd1;
                            tone_start = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= '0;
            gap_cnt_q  <= '0;
            hdr_long_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            hdr_long_q <= hdr_long_d;
            armed_q    <= armed_d;
        end
    end

    cas_tone_gen u_tone (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce_run),
        .clr      (tone_clr),
        .start    (tone_start),
        .half_len (tone_len),
        .num_half (tone_num),
        .level    (tone_level),
        .done     (tone_done)
    );

endmodule
